// File: rtl/ad7768_ctrl.sv
// rtl/ad7768_ctrl.sv - AD7768 dual-bus SPI configuration/sync sequencer
// Host words are queued, shifted out MSB-first in SPI mode 3 and optionally followed by a sync pulse.
module ad7768_ctrl #(
  parameter int CLKDIV    = 4,
  parameter int FIFO_LOG2 = 2,
  parameter int CS_GAP    = 2,
  parameter int SYNC_LEN  = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic        busy,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic [1:0]  acs_n,
  output logic        asclk,
  output logic [1:0]  amosi,
  input  logic [1:0]  amiso,
  output logic [1:0]  sync_n
);

  localparam int DEPTH = 2 ** FIFO_LOG2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_SYNC  = 3'd5;

  logic [19:0]          mem [DEPTH];
  logic [FIFO_LOG2-1:0] wptr;
  logic [FIFO_LOG2-1:0] rptr;
  logic [FIFO_LOG2:0]   count;
  logic                 push;
  logic                 pop;
  logic [19:0]          head;

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [3:0]  bitcnt;
  logic [15:0] sreg;
  logic [15:0] rx;
  logic [1:0]  mask_q;
  logic        rd_q;
  logic        sync_q;
  logic        miso_bit;

  assign wready   = (count != (FIFO_LOG2 + 1)'(DEPTH));
  assign push     = wvalid & wready;
  assign pop      = (state == S_IDLE) && (count != '0);
  assign head     = mem[rptr];
  assign busy     = (count != '0) || (state != S_IDLE);
  // Bus 0 has priority for read-back, including the broadcast mask 2'b11.
  assign miso_bit = mask_q[0] ? amiso[0] : amiso[1];

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      sreg   <= '0;
      rx     <= '0;
      mask_q <= '0;
      rd_q   <= 1'b0;
      sync_q <= 1'b0;
      acs_n  <= 2'b11;
      asclk  <= 1'b1;
      amosi  <= 2'b00;
      sync_n <= 2'b11;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          // A zero mask drops the word without touching either bus.
          if (pop && (head[19:18] != 2'b00)) begin
            mask_q <= head[19:18];
            rd_q   <= head[16];
            sync_q <= head[17];
            sreg   <= head[15:0];
            acs_n  <= ~head[19:18];
            amosi  <= {2{head[15]}};
            asclk  <= 1'b1;
            cnt    <= 16'(CLKDIV - 1);
            state  <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            asclk  <= 1'b0;
            bitcnt <= '0;
            cnt    <= 16'(CLKDIV - 1);
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!asclk) begin
            asclk <= 1'b1;
            rx    <= {rx[14:0], miso_bit};
            cnt   <= 16'(CLKDIV - 1);
          end else if (bitcnt == 4'd15) begin
            cnt   <= 16'(CLKDIV - 1);
            state <= S_TRAIL;
          end else begin
            asclk  <= 1'b0;
            amosi  <= {2{sreg[14]}};
            sreg   <= {sreg[14:0], 1'b0};
            bitcnt <= bitcnt + 1'b1;
            cnt    <= 16'(CLKDIV - 1);
          end
        end
        S_TRAIL: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            acs_n <= 2'b11;
            if (rd_q) begin
              rdata  <= rx;
              rvalid <= 1'b1;
            end
            cnt   <= 16'(CS_GAP - 1);
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (sync_q) begin
            sync_n <= ~mask_q;
            cnt    <= 16'(SYNC_LEN - 1);
            state  <= S_SYNC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SYNC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            sync_n <= 2'b11;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
